// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART frame scheduler
// and the 8N1 transmitter it feeds.
package uart_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;
    localparam int         ID_W        = 4;

    localparam int CLK_HZ   = 50_000_000;
    localparam int BAUD     = 115_200;
    localparam int BAUD_DIV = CLK_HZ / BAUD;

    typedef enum logic [2:0] {
        F_IDLE,
        F_ARB,
        F_SOF,
        F_ID,
        F_PAY,
        F_CHK
    } frame_state_e;

    typedef enum logic [1:0] {
        I_READY,
        I_HOLD,
        I_WAIT
    } issue_state_e;

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin picker: first requester above the
// pointer, with modulo wrap, as one-hot grant plus index.
module uart_rr_arb #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        // Walk downward so the nearest channel after the pointer wins.
        for (int i = N; i >= 1; i--) begin
            if (req_i[(int'(ptr_i) + i) % N]) begin
                idx_o = PW'((int'(ptr_i) + i) % N);
                any_o = 1'b1;
            end
        end
        if (any_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin frame scheduler sharing one 8N1 transmitter:
// SOF, channel ID, payload, XOR checksum per granted frame.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int         NUM_CH   = 4,
    parameter logic [7:0] SOF_BYTE = SOF_DEFAULT
) (
    input  logic                  clk50M,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     ch_valid,
    input  logic [8*NUM_CH-1:0]   ch_data,
    input  logic [NUM_CH-1:0]     ch_last,
    output logic [NUM_CH-1:0]     ch_ready,
    output logic                  tx_trig,
    output logic [7:0]            tx_data,
    input  logic                  tx_idle,
    output logic                  busy,
    output logic [ID_W-1:0]       grant_id
);

    localparam int PW = $clog2(NUM_CH);

    frame_state_e        fst_q, fst_d;
    issue_state_e        ist_q, ist_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]     gid_q, gid_d;
    logic [NUM_CH-1:0]   gsel_q, gsel_d;
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          dat_q, dat_d;
    logic                pend_q, pend_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic [NUM_CH-1:0]   arb_gnt;
    logic [PW-1:0]       arb_idx;
    logic                arb_any;

    logic [7:0]          cur_byte;
    logic                cur_last;
    logic                cur_valid;
    logic                want;
    logic [7:0]          ibyte;
    logic                trig;
    logic                rdy;
    logic                hs;
    logic [7:0]          id_byte;

    uart_rr_arb #(
        .N  (NUM_CH),
        .PW (PW)
    ) u_arb (
        .req_i (ch_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign id_byte = {{(8 - ID_W){1'b0}}, gid_q};

    always_comb begin
        cur_byte  = '0;
        cur_last  = 1'b0;
        cur_valid = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gsel_q[k]) begin
                cur_byte  = cur_byte | ch_data[8*k +: 8];
                cur_last  = cur_last | ch_last[k];
                cur_valid = cur_valid | ch_valid[k];
            end
        end
    end

    // Byte offered to the transmitter in the current frame state.
    always_comb begin
        want  = 1'b0;
        ibyte = dat_q;
        unique case (fst_q)
            F_SOF: begin
                want  = 1'b1;
                ibyte = SOF_BYTE;
            end
            F_ID: begin
                want  = 1'b1;
                ibyte = id_byte;
            end
            F_PAY: begin
                want  = pend_q;
                ibyte = dat_q;
            end
            F_CHK: begin
                want  = pend_q | ~done_q;
                ibyte = pend_q ? dat_q : csum_q;
            end
            default: begin
                want  = 1'b0;
                ibyte = dat_q;
            end
        endcase
    end

    assign trig = want & (ist_q == I_READY) & tx_idle;
    assign rdy  = (fst_q == F_PAY) & (ist_q == I_READY) & tx_idle & ~pend_q;
    assign hs   = rdy & cur_valid;

    assign ch_ready = rdy ? gsel_q : '0;
    assign tx_trig  = trig;
    assign tx_data  = trig ? ibyte : dat_q;
    assign busy     = busy_q;
    assign grant_id = gid_q;

    // HOLD masks tx_idle for the cycle before the transmitter reacts.
    always_comb begin
        ist_d = ist_q;
        unique case (ist_q)
            I_READY: if (trig) ist_d = I_HOLD;
            I_HOLD:  ist_d = I_WAIT;
            I_WAIT:  if (tx_idle) ist_d = I_READY;
            default: ist_d = I_READY;
        endcase
    end

    always_comb begin
        fst_d  = fst_q;
        ptr_d  = ptr_q;
        gid_d  = gid_q;
        gsel_d = gsel_q;
        csum_d = csum_q;
        pend_d = pend_q;
        done_d = done_q;
        busy_d = busy_q;
        dat_d  = dat_q;
        if (trig) dat_d = ibyte;
        if (hs)   dat_d = cur_byte;
        unique case (fst_q)
            F_IDLE: begin
                busy_d = 1'b0;
                if (|ch_valid) fst_d = F_ARB;
            end
            F_ARB: begin
                if (arb_any) begin
                    gid_d  = ID_W'(arb_idx);
                    gsel_d = arb_gnt;
                    ptr_d  = arb_idx;
                    busy_d = 1'b1;
                    csum_d = '0;
                    pend_d = 1'b0;
                    done_d = 1'b0;
                    fst_d  = F_SOF;
                end else begin
                    fst_d  = F_IDLE;
                end
            end
            F_SOF: begin
                if (trig) fst_d = F_ID;
            end
            F_ID: begin
                if (trig) begin
                    csum_d = csum_q ^ id_byte;
                    fst_d  = F_PAY;
                end
            end
            F_PAY: begin
                if (trig) pend_d = 1'b0;
                if (hs) begin
                    pend_d = 1'b1;
                    csum_d = csum_q ^ cur_byte;
                    if (cur_last) fst_d = F_CHK;
                end
            end
            F_CHK: begin
                // Last payload byte may still be pending ahead of the checksum.
                if (trig) begin
                    if (pend_q) pend_d = 1'b0;
                    else        done_d = 1'b1;
                end
                if (done_q && ist_q == I_WAIT && tx_idle) begin
                    busy_d = 1'b0;
                    fst_d  = F_IDLE;
                end
            end
            default: fst_d = F_IDLE;
        endcase
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            fst_q  <= F_IDLE;
            ist_q  <= I_READY;
            ptr_q  <= PW'(NUM_CH - 1);
            gid_q  <= '0;
            gsel_q <= '0;
            csum_q <= '0;
            dat_q  <= '0;
            pend_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            fst_q  <= fst_d;
            ist_q  <= ist_d;
            ptr_q  <= ptr_d;
            gid_q  <= gid_d;
            gsel_q <= gsel_d;
            csum_q <= csum_d;
            dat_q  <= dat_d;
            pend_q <= pend_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched with a lagging-busy
// transmitter model and per-channel byte-stream drivers.
module tb_uart_tx_sched;

    localparam int NCH  = 4;
    localparam int CHAR = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    ch_valid;
    logic [8*NCH-1:0]  ch_data;
    logic [NCH-1:0]    ch_last;
    logic [NCH-1:0]    ch_ready;
    logic              tx_trig;
    logic [7:0]        tx_data;
    logic              tx_idle;
    logic              busy;
    logic [3:0]        grant_id;

    uart_tx_sched #(.NUM_CH(NCH), .SOF_BYTE(8'hA5)) dut (
        .clk50M   (clk),
        .rst      (rst),
        .ch_valid (ch_valid),
        .ch_data  (ch_data),
        .ch_last  (ch_last),
        .ch_ready (ch_ready),
        .tx_trig  (tx_trig),
        .tx_data  (tx_data),
        .tx_idle  (tx_idle),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [8:0] sbq [$];
    logic [8:0] chq [NCH][$];
    logic [7:0] pl_q [$];
    logic [NCH-1:0] stall = '0;
    int hs_cnt [NCH];
    int trig_cnt = 0;
    int char_cnt = 0;
    int cyc = 0;
    int vrise_cyc = 0;
    int lat_cyc = 0;
    logic arm_lat = 1'b0;
    logic [7:0] last_byte = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_frame(input int ch);
        logic [7:0] cs;
        cs = 8'(ch);
        sbq.push_back({1'b0, 8'hA5});
        sbq.push_back({1'b1, 8'(ch)});
        for (int i = 0; i < pl_q.size(); i++) begin
            cs = cs ^ pl_q[i];
            sbq.push_back({1'b0, pl_q[i]});
            chq[ch].push_back({(i == pl_q.size() - 1), pl_q[i]});
        end
        sbq.push_back({1'b0, cs});
        pl_q.delete();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((sbq.size() != 0 || busy || !tx_idle) && n < budget);
        chk("done", {29'h0, busy, !tx_idle, sbq.size() != 0}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Transmitter: busy flag rises one cycle after the trigger.
    initial begin
        logic lag;
        int cnt;
        logic [8:0] e;
        logic [31:0] expv;
        lag = 1'b0;
        cnt = 0;
        tx_idle = 1'b1;
        forever begin
            @(posedge clk);
            if (tx_trig) begin
                trig_cnt++;
                chk("trig_ok", {30'h0, lag, tx_idle}, 32'h1);
                if (arm_lat) begin
                    lat_cyc = cyc;
                    arm_lat = 1'b0;
                end
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    expv = {24'h0, e[7:0]};
                end else begin
                    e = '0;
                    expv = 32'hFFFF_FFFF;
                end
                chk("line_byte", {24'h0, tx_data}, expv);
                if (e[8]) chk("grant_id", {28'h0, grant_id}, {24'h0, e[7:0]});
                last_byte = tx_data;
            end
            if (lag) begin
                tx_idle <= 1'b0;
                cnt = CHAR;
                lag = 1'b0;
            end else if (!tx_idle && cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    tx_idle <= 1'b1;
                    char_cnt++;
                end
            end
            if (tx_trig) lag = 1'b1;
            cyc++;
        end
    end

    // Channel drivers: present queue heads, pop on valid & ready.
    initial begin
        logic [NCH-1:0] v, l, hs;
        logic [8*NCH-1:0] d;
        logic prev_any;
        prev_any = 1'b0;
        for (int k = 0; k < NCH; k++) hs_cnt[k] = 0;
        ch_valid = '0;
        ch_data  = '0;
        ch_last  = '0;
        forever begin
            @(negedge clk);
            v = '0;
            l = '0;
            d = '0;
            for (int k = 0; k < NCH; k++) begin
                if (chq[k].size() > 0 && !stall[k]) begin
                    v[k] = 1'b1;
                    l[k] = chq[k][0][8];
                    d[8*k +: 8] = chq[k][0][7:0];
                end
            end
            ch_valid = v;
            ch_last  = l;
            ch_data  = d;
            if (!prev_any && |v) vrise_cyc = cyc;
            prev_any = |v;
            #1;
            hs = ch_valid & ch_ready;
            @(posedge clk);
            for (int k = 0; k < NCH; k++) begin
                if (hs[k]) begin
                    void'(chq[k].pop_front());
                    hs_cnt[k]++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int t0, c0, h0, n;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_trig", {31'h0, tx_trig}, 32'h0);
        chk("rst_data", {24'h0, tx_data}, 32'h0);
        chk("rst_ready", {28'h0, ch_ready}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_gid", {28'h0, grant_id}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single frame on channel 2
        t0 = trig_cnt;
        c0 = char_cnt;
        arm_lat = 1'b1;
        pl_q.push_back(8'h11);
        pl_q.push_back(8'h22);
        add_frame(2);
        repeat (6) @(posedge clk);
        #1;
        chk("t1_busy_hi", {31'h0, busy}, 32'h1);
        chk("t1_gid", {28'h0, grant_id}, 32'h2);
        wait_done(400);
        chk("t1_latency", lat_cyc - vrise_cyc, 32'd2);
        chk("t1_trigs", trig_cnt - t0, 32'd5);
        chk("t1_chars", char_cnt - c0, 32'd5);

        // Channels 0 and 3 contending with 1-byte frames
        do_reset();
        pl_q.push_back(8'h40); add_frame(0);
        pl_q.push_back(8'h50); add_frame(3);
        pl_q.push_back(8'h41); add_frame(0);
        pl_q.push_back(8'h51); add_frame(3);
        wait_done(800);

        // Channel 1 stalls mid-payload; channel 0 waits its turn
        do_reset();
        h0 = hs_cnt[1];
        pl_q.push_back(8'h10);
        pl_q.push_back(8'h20);
        pl_q.push_back(8'h30);
        add_frame(1);
        n = 0;
        while (hs_cnt[1] == h0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        stall[1] = 1'b1;
        chk("t3_first_hs", hs_cnt[1] - h0, 32'd1);
        pl_q.push_back(8'h66);
        add_frame(0);
        repeat (40) @(posedge clk);
        t0 = trig_cnt;
        repeat (460) @(posedge clk);
        #1;
        chk("t3_stall_trig", trig_cnt - t0, 32'd0);
        chk("t3_stall_gid", {28'h0, grant_id}, 32'h1);
        chk("t3_stall_busy", {31'h0, busy}, 32'h1);
        stall[1] = 1'b0;
        wait_done(800);
        chk("t3_hs", hs_cnt[1] - h0, 32'd3);

        // Reset in the middle of a payload
        h0 = hs_cnt[2];
        for (int i = 1; i <= 4; i++) pl_q.push_back(8'(i));
        add_frame(2);
        n = 0;
        while (hs_cnt[2] < h0 + 2 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t5_hs", hs_cnt[2] - h0, 32'd2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_trig", {31'h0, tx_trig}, 32'h0);
        chk("t5_ready", {28'h0, ch_ready}, 32'h0);
        chk("t5_busy", {31'h0, busy}, 32'h0);
        chk("t5_gid", {28'h0, grant_id}, 32'h0);
        sbq.delete();
        for (int k = 0; k < NCH; k++) chq[k].delete();
        @(negedge clk);
        rst = 1'b0;
        pl_q.push_back(8'h77); add_frame(0);
        pl_q.push_back(8'h88); add_frame(3);
        wait_done(600);

        // Long frame: 255 bytes of FF
        do_reset();
        h0 = hs_cnt[0];
        for (int i = 0; i < 255; i++) pl_q.push_back(8'hFF);
        add_frame(0);
        wait_done(9000);
        chk("t6_hs", hs_cnt[0] - h0, 32'd255);
        chk("t6_csum", {24'h0, last_byte}, 32'hFF);

        chk("trig_vs_char", trig_cnt, char_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
